// File: rtl/mem_stage_pkg.sv
// RV64 memory stage shared definitions.
// Op codes, FSM encodings and op classification helpers.
package riscv_mem_pkg;

  localparam int MEM_XLEN = 64;
  localparam int MEM_RA_W = 5;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LD   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_LHU  = 4'd6;
  localparam logic [3:0] MEM_LWU  = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;
  localparam logic [3:0] MEM_SH   = 4'd9;
  localparam logic [3:0] MEM_SW   = 4'd10;
  localparam logic [3:0] MEM_SD   = 4'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LWU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] access_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: sz = 2'd0;
      MEM_LH, MEM_LHU, MEM_SH: sz = 2'd1;
      MEM_LW, MEM_LWU, MEM_SW: sz = 2'd2;
      default:                 sz = 2'd3;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(
    input logic [3:0] op,
    input logic [2:0] a
  );
    logic m;
    case (access_size(op))
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = |a;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus.
// master = memory stage, slave = memory.
interface mem_stage_if;
  import riscv_mem_pkg::*;

  logic                dmem_req_valid;
  logic                dmem_req_ready;
  logic [MEM_XLEN-1:0] dmem_addr;
  logic                dmem_we;
  logic [MEM_XLEN-1:0] dmem_wdata;
  logic [7:0]          dmem_wstrb;
  logic                dmem_rsp_valid;
  logic [MEM_XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid,
    input  dmem_req_ready,
    output dmem_addr,
    output dmem_we,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    output dmem_req_ready,
    input  dmem_addr,
    input  dmem_we,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_rsp_valid,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane packing for stores and lane extraction
// with sign/zero extension for loads.
module mem_align
  import riscv_mem_pkg::*;
(
  input  logic [3:0]          memop_i,
  input  logic [2:0]          off_i,
  input  logic [MEM_XLEN-1:0] sdata_i,
  input  logic [MEM_XLEN-1:0] rdata_i,
  output logic [MEM_XLEN-1:0] wdata_o,
  output logic [7:0]          wstrb_o,
  output logic [MEM_XLEN-1:0] ldata_o
);

  logic [MEM_XLEN-1:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  // store data replicated across lanes, strobes pick the lanes
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    unique case (1'b1)
      memop_i == MEM_SB: begin
        wdata_o = {8{sdata_i[7:0]}};
        wstrb_o = 8'h01 << off_i;
      end
      memop_i == MEM_SH: begin
        wdata_o = {4{sdata_i[15:0]}};
        wstrb_o = 8'h03 << off_i;
      end
      memop_i == MEM_SW: begin
        wdata_o = {2{sdata_i[31:0]}};
        wstrb_o = 8'h0F << off_i;
      end
      memop_i == MEM_SD: begin
        wdata_o = sdata_i;
        wstrb_o = 8'hFF;
      end
      default: ;
    endcase
  end

  // load lane shifted down, then extended
  always_comb begin
    ldata_o = '0;
    unique case (1'b1)
      memop_i == MEM_LB:
        ldata_o = {{56{sh[7]}}, sh[7:0]};
      memop_i == MEM_LBU:
        ldata_o = {56'b0, sh[7:0]};
      memop_i == MEM_LH:
        ldata_o = {{48{sh[15]}}, sh[15:0]};
      memop_i == MEM_LHU:
        ldata_o = {48'b0, sh[15:0]};
      memop_i == MEM_LW:
        ldata_o = {{32{sh[31]}}, sh[31:0]};
      memop_i == MEM_LWU:
        ldata_o = {32'b0, sh[31:0]};
      memop_i == MEM_LD:
        ldata_o = sh;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues loads/stores on the
// dmem bus and emits one writeback record per instruction.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN       = MEM_XLEN,
  parameter int REG_ADDR_W = MEM_RA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_result,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [3:0]            in_memop,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  mem_stage_if.master           dmem,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_wen,
  output logic [XLEN-1:0]       wb_data,
  output logic                  misalign
);

  logic [1:0]            state_q, state_d;
  logic [XLEN-1:0]       addr_q, sdata_q;
  logic [3:0]            memop_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wen_q;

  logic                  wb_valid_d, wb_wen_d, mis_d;
  logic [REG_ADDR_W-1:0] wb_rd_d;
  logic [XLEN-1:0]       wb_data_d;

  logic            accept, in_mem, in_mis;
  logic            in_req, in_wait, st_q;
  logic [XLEN-1:0] wdata, ldata;
  logic [7:0]      wstrb;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign in_mem   = is_load(in_memop) | is_store(in_memop);
  assign in_mis   = in_mem & misaligned(in_memop, in_result[2:0]);
  assign in_req   = (state_q == S_REQ);
  assign in_wait  = (state_q == S_WAIT);
  assign st_q     = is_store(memop_q);

  mem_align u_align (
    .memop_i (memop_q),
    .off_i   (addr_q[2:0]),
    .sdata_i (sdata_q),
    .rdata_i (dmem.dmem_rdata),
    .wdata_o (wdata),
    .wstrb_o (wstrb),
    .ldata_o (ldata)
  );

  assign dmem.dmem_req_valid = in_req;
  assign dmem.dmem_addr  = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dmem.dmem_we    = in_req & st_q;
  assign dmem.dmem_wdata = in_req ? wdata : '0;
  assign dmem.dmem_wstrb = in_req ? wstrb : '0;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (accept && in_mem && !in_mis)
          state_d = S_REQ;
      S_REQ:
        if (dmem.dmem_req_ready)
          state_d = st_q ? S_IDLE : S_WAIT;
      S_WAIT:
        if (dmem.dmem_rsp_valid)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // writeback record for the next cycle
  always_comb begin
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_wen_d   = 1'b0;
    wb_data_d  = '0;
    mis_d      = 1'b0;
    unique case (1'b1)
      accept && !in_mem: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = in_rd;
        wb_wen_d   = in_wen;
        wb_data_d  = in_result;
      end
      accept && in_mis: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = in_rd;
        wb_data_d  = in_result;
        mis_d      = 1'b1;
      end
      in_req && dmem.dmem_req_ready && st_q: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
      end
      in_wait && dmem.dmem_rsp_valid: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_wen_d   = wen_q;
        wb_data_d  = ldata;
      end
      default: ;
    endcase
  end

  // state, latched instruction and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sdata_q  <= '0;
      memop_q  <= MEM_NONE;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
      wb_data  <= '0;
      misalign <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_valid <= wb_valid_d;
      wb_rd    <= wb_rd_d;
      wb_wen   <= wb_wen_d;
      wb_data  <= wb_data_d;
      misalign <= mis_d;
      if (accept) begin
        addr_q  <= in_result;
        sdata_q <= in_store_data;
        memop_q <= in_memop;
        rd_q    <= in_rd;
        wen_q   <= in_wen;
      end
    end
  end

endmodule
